reg_files: RTL and testbench
============================

// Module: reg_files
// PURPOSE
// - MIPS general-purpose register file: 32 x 32-bit registers, two combinational read ports (A, B), one synchronous write port (W).
// - Sits in the decode/writeback path of the CPU core.
// - rs/rt operands are read on A/B; the ALU/memory result is written back on W.
// - Register 0 reads as constant zero.
// PARAMETERS
// - DATA_W   32  width of each register and of every data port
// - ADDR_W   5   register index width
// - NREGS    32  number of registers (= 2**ADDR_W)
// PORTS
// - clk     in   1       clock; all state changes on rising edge
// - aclr    in   1       reset, synchronous, active-high; clears every register
// - addr_a  in   ADDR_W  read port A register index
// - addr_b  in   ADDR_W  read port B register index
// - addr_w  in   ADDR_W  write register index
// - wren    in   1       write enable
// - data_w  in   DATA_W  write data
// - data_a  out  DATA_W  contents of register addr_a
// - data_b  out  DATA_W  contents of register addr_b
// BEHAVIOUR
// - Storage: array gpregs[0:NREGS-1] of DATA_W bits. Benches probe it hierarchically, so keep it an unpacked array under that name.
// - Reset: on a rising clk with aclr=1, all gpregs <= 0.
//   - Reset has priority over a simultaneous write.
//   - The write is dropped, including a write issued mid-operation.
//   - After that edge, data_a = data_b = 0 for every address.
// - Write: on a rising clk with aclr=0 and wren=1, gpregs[addr_w] <= data_w.
//   - wren=0 leaves every register unchanged.
//   - A write to addr_w=0 is ignored; gpregs[0] stays 0.
// - Read: purely combinational, zero latency.
//   - data_a = (addr_a==0) ? 0 : gpregs[addr_a]. Same rule for data_b.
//   - Both ports may address the same register; both return the same value.
// - No write-to-read bypass.
//   - A read of addr_w in the write cycle returns the old value.
//   - The new value appears on the outputs right after the write edge.
// - Before the first reset edge, contents are undefined (X in simulation).
// - All addresses 0..31 are valid; no out-of-range case exists.
// STRUCTURE
// - Shared package regfile_pkg:
//   - DATA_W and ADDR_W constants.
//   - typedef reg_addr_t [ADDR_W-1:0] and typedef word_t [DATA_W-1:0].
//   - Named indices REG_ZERO=0 and REG_RA=31.
// - One natural sub-module: regfile_rdport.
//   - Zero-forcing read mux: address in, array in, word out.
//   - Instantiated twice, for ports A and B.
// - Write logic and storage stay in reg_files.
// TESTING
// - Reset: aclr=1 for one edge, then aclr=0 -> data_a/data_b = 0 for all 32 addresses on both ports.
// - Write r0: addr_w=0, data_w=F0F0F0F0, wren=1, one edge; then addr_a=addr_b=0 -> both outputs 0.
// - Write r1: addr_w=1, data_w=F0F0F0F0, wren=1, one edge; then wren=0, addr_a=addr_b=1 -> both outputs F0F0F0F0.
// - Disabled write: wren=0, addr_w=2, data_w=12345678, one edge -> r2 still reads 0.
//   Same-cycle read: addr_a=3 while writing r3=DEADBEEF -> data_a is 0 before the edge, DEADBEEF after it.
// - Reset priority: r31=AAAA5555 written; next edge aclr=1 with wren=1, addr_w=31, data_w=11111111 -> r31 reads 0 afterwards.
// - Sweep: write r(i)=i*0x01010101 for i=1..31, read pairs (i, 32-i) -> both ports return the expected values; r0 stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, types and named indices for the register file
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = reg_addr_t'(0);
  localparam reg_addr_t REG_RA   = reg_addr_t'(31);

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - combinational read mux that forces register 0 to zero
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREGS  = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [NREGS],
  output logic [DATA_W-1:0] data
);

  // r0 is hardwired zero regardless of what the storage array holds
  always_comb begin
    data = '0;
    if (addr != ADDR_W'(REG_ZERO)) begin
      data = regs[addr];
    end
  end

endmodule

// File: rtl/reg_files.sv
// rtl/reg_files.sv - 32x32 MIPS register file, two async read ports, one sync write port
module reg_files
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREGS  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic              wren,
  input  logic [DATA_W-1:0] data_w,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b
);

  logic [DATA_W-1:0] gpregs [NREGS];

  // Reset clears everything and wins over a same-edge write; r0 is never written
  always_ff @(posedge clk) begin
    if (aclr) begin
      for (int i = 0; i < NREGS; i++) begin
        gpregs[i] <= '0;
      end
    end else if (wren && (addr_w != ADDR_W'(REG_ZERO))) begin
      gpregs[addr_w] <= data_w;
    end
  end

  // No write-to-read bypass: reads see the array as it stood before the edge
  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rdport_a (
    .addr (addr_a),
    .regs (gpregs),
    .data (data_a)
  );

  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rdport_b (
    .addr (addr_b),
    .regs (gpregs),
    .data (data_b)
  );

endmodule

// File: tb/tb_reg_files.sv
// tb/tb_reg_files.sv - self-checking bench for reg_files with a reference array model
module tb_reg_files;

  logic        clk;
  logic        aclr;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic [4:0]  addr_w;
  logic        wren;
  logic [31:0] data_w;
  logic [31:0] data_a;
  logic [31:0] data_b;

  int checks;
  int errors;
  logic [31:0] model [32];

  reg_files dut (
    .clk    (clk),
    .aclr   (aclr),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .addr_w (addr_w),
    .wren   (wren),
    .data_w (data_w),
    .data_a (data_a),
    .data_b (data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  // one rising edge; the model takes the same inputs the DUT saw
  task automatic tick();
    @(posedge clk);
    if (aclr) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (wren && addr_w != 5'd0) begin
      model[addr_w] = data_w;
    end
    #1;
  endtask

  task automatic read_pair(input string tag, input logic [4:0] a, input logic [4:0] b);
    addr_a = a;
    addr_b = b;
    #1;
    check({tag, "_a"}, data_a, model_read(a));
    check({tag, "_b"}, data_b, model_read(b));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    aclr   = 1'b1;
    wren   = 1'b0;
    addr_a = '0;
    addr_b = '0;
    addr_w = '0;
    data_w = '0;

    // reset: every address reads zero on both ports
    tick();
    aclr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      addr_a = 5'(i);
      addr_b = 5'(31 - i);
      #1;
      check("reset_a", data_a, 32'h0);
      check("reset_b", data_b, 32'h0);
    end

    // write to r0 is ignored
    addr_w = 5'd0; data_w = 32'hF0F0F0F0; wren = 1'b1;
    tick();
    wren = 1'b0; addr_a = 5'd0; addr_b = 5'd0; #1;
    check("r0_a", data_a, 32'h0);
    check("r0_b", data_b, 32'h0);

    // write to r1, both ports read it
    addr_w = 5'd1; data_w = 32'hF0F0F0F0; wren = 1'b1;
    tick();
    wren = 1'b0; addr_a = 5'd1; addr_b = 5'd1; #1;
    check("r1_a", data_a, 32'hF0F0F0F0);
    check("r1_b", data_b, 32'hF0F0F0F0);

    // disabled write leaves r2 at zero
    addr_w = 5'd2; data_w = 32'h12345678; wren = 1'b0;
    tick();
    addr_a = 5'd2; #1;
    check("r2_nowr", data_a, 32'h0);

    // same-cycle read returns the old value, new value after the edge
    addr_a = 5'd3; addr_w = 5'd3; data_w = 32'hDEADBEEF; wren = 1'b1; #1;
    check("r3_before", data_a, 32'h0);
    tick();
    wren = 1'b0; #1;
    check("r3_after", data_a, 32'hDEADBEEF);

    // reset beats a simultaneous write
    addr_w = 5'd31; data_w = 32'hAAAA5555; wren = 1'b1;
    tick();
    addr_a = 5'd31; #1;
    check("r31_wr", data_a, 32'hAAAA5555);
    aclr = 1'b1; data_w = 32'h11111111;
    tick();
    aclr = 1'b0; wren = 1'b0; #1;
    check("r31_rst", data_a, 32'h0);
    addr_a = 5'd1; #1;
    check("r1_rst", data_a, 32'h0);

    // sweep: r(i) = i * 0x01010101, read pairs (i, 32-i)
    for (int i = 1; i < 32; i++) begin
      addr_w = 5'(i); data_w = 32'(i) * 32'h01010101; wren = 1'b1;
      tick();
    end
    wren = 1'b0;
    for (int i = 1; i < 32; i++) begin
      addr_a = 5'(i); addr_b = 5'(32 - i); #1;
      check("sweep_a", data_a, 32'(i) * 32'h01010101);
      check("sweep_b", data_b, 32'(32 - i) * 32'h01010101);
    end
    addr_a = 5'd0; addr_b = 5'd0; #1;
    check("sweep_r0_a", data_a, 32'h0);
    check("sweep_r0_b", data_b, 32'h0);

    // random traffic against the model, reads checked before each edge
    for (int n = 0; n < 500; n++) begin
      aclr   = ($urandom_range(0, 59) == 0);
      wren   = $urandom_range(0, 1);
      addr_w = 5'($urandom_range(0, 31));
      data_w = $urandom;
      read_pair("rand_pre", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) read_pair("rand_same", addr_w, addr_w);
      tick();
      read_pair("rand_post", addr_w, 5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
